// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave exposing CTRL, CFG and SCRATCH registers plus a free-running cycle counter.
// The write path (WIDLE/WRESP) and the read path (RIDLE/RDATA) run independently.
module axi4lite_slave_regs #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      A_CLK,
    input  logic                      A_RSTn,
    // write address channel
    input  logic                      AW_VALID,
    input  logic [AXI_ADDR_WIDTH-1:0] AW_ADDR,
    input  logic [2:0]                AW_PROT,
    output logic                      AW_READY,
    // write data channel
    input  logic                      W_VALID,
    input  logic [AXI_DATA_WIDTH-1:0] W_DATA,
    input  logic [AXI_STRB_WIDTH-1:0] W_STRB,
    output logic                      W_READY,
    // write response channel
    output logic                      B_VALID,
    output logic [1:0]                B_RESP,
    input  logic                      B_READY,
    // read address channel
    input  logic                      AR_VALID,
    input  logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
    input  logic [2:0]                AR_PROT,
    output logic                      AR_READY,
    // read data channel
    output logic                      R_VALID,
    output logic [AXI_DATA_WIDTH-1:0] R_DATA,
    output logic [1:0]                R_RESP,
    input  logic                      R_READY,
    // live register values
    output logic [AXI_DATA_WIDTH-1:0] CTRL_O,
    output logic [AXI_DATA_WIDTH-1:0] CFG_O
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic {WIdle, WResp} wstate_t;
    typedef enum logic {RIdle, RData} rstate_t;

    function automatic logic [AXI_DATA_WIDTH-1:0] apply_strb(
        input logic [AXI_DATA_WIDTH-1:0] old_val,
        input logic [AXI_DATA_WIDTH-1:0] new_val,
        input logic [AXI_STRB_WIDTH-1:0] strb
    );
        logic [AXI_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(AXI_STRB_WIDTH); i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Registers
    logic [AXI_DATA_WIDTH-1:0] ctrl_q;
    logic [AXI_DATA_WIDTH-1:0] cfg_q;
    logic [AXI_DATA_WIDTH-1:0] scratch_q;
    logic [AXI_DATA_WIDTH-1:0] cycle_q;

    // Held low for the first cycle after reset so READYs only rise once reset is released.
    logic out_of_reset_q;

    // Write path state
    wstate_t                   wstate_q, wstate_d;
    logic                      aw_held_q, w_held_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic [AXI_STRB_WIDTH-1:0] w_strb_q;
    logic [1:0]                b_resp_q;

    logic                      aw_ready, w_ready;
    logic                      aw_hs, w_hs;
    logic                      commit;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_data;
    logic [AXI_STRB_WIDTH-1:0] wr_strb;
    logic                      wr_hit, wr_ok;
    logic [1:0]                wr_idx;

    // Read path state
    rstate_t                   rstate_q, rstate_d;
    logic [AXI_DATA_WIDTH-1:0] r_data_q;
    logic [1:0]                r_resp_q;

    logic                      ar_ready, ar_hs;
    logic                      rd_hit;
    logic [1:0]                rd_idx;
    logic [AXI_DATA_WIDTH-1:0] rd_val;
    logic [1:0]                rd_resp;

    logic unused_bits;
    assign unused_bits = ^{AW_PROT, AR_PROT, wr_addr[1:0], AR_ADDR[1:0]};

    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            out_of_reset_q <= 1'b0;
        end else begin
            out_of_reset_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    assign aw_ready = out_of_reset_q && (wstate_q == WIdle) && !aw_held_q;
    assign w_ready  = out_of_reset_q && (wstate_q == WIdle) && !w_held_q;
    assign aw_hs    = AW_VALID && aw_ready;
    assign w_hs     = W_VALID && w_ready;

    // Commit as soon as both halves are available, whether held or arriving now.
    assign commit  = (wstate_q == WIdle) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_addr = aw_held_q ? aw_addr_q : AW_ADDR;
    assign wr_data = w_held_q ? w_data_q : W_DATA;
    assign wr_strb = w_held_q ? w_strb_q : W_STRB;
    assign wr_hit  = ((wr_addr >> 4) == '0);
    assign wr_idx  = wr_addr[3:2];
    assign wr_ok   = wr_hit && (wr_idx != 2'd3);

    always_comb begin
        wstate_d = wstate_q;
        unique case (wstate_q)
            WIdle:   if (commit) wstate_d = WResp;
            WResp:   if (B_READY) wstate_d = WIdle;
            default: wstate_d = WIdle;
        endcase
    end

    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            wstate_q  <= WIdle;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= RespOkay;
        end else begin
            wstate_q <= wstate_d;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                b_resp_q  <= wr_ok ? RespOkay : RespSlverr;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_addr_q <= AW_ADDR;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= W_DATA;
                    w_strb_q <= W_STRB;
                end
            end
        end
    end

    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            ctrl_q    <= '0;
            cfg_q     <= '0;
            scratch_q <= '0;
        end else if (commit && wr_ok) begin
            case (wr_idx)
                2'd0:    ctrl_q    <= apply_strb(ctrl_q, wr_data, wr_strb);
                2'd1:    cfg_q     <= apply_strb(cfg_q, wr_data, wr_strb);
                2'd2:    scratch_q <= apply_strb(scratch_q, wr_data, wr_strb);
                default: ;
            endcase
        end
    end

    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + AXI_DATA_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    assign ar_ready = out_of_reset_q && (rstate_q == RIdle);
    assign ar_hs    = AR_VALID && ar_ready;
    assign rd_hit   = ((AR_ADDR >> 4) == '0);
    assign rd_idx   = AR_ADDR[3:2];

    // Sampled from the current register values, so a same-edge write is not visible.
    always_comb begin
        rd_val  = '0;
        rd_resp = RespSlverr;
        if (rd_hit) begin
            rd_resp = RespOkay;
            case (rd_idx)
                2'd0:    rd_val = ctrl_q;
                2'd1:    rd_val = cfg_q;
                2'd2:    rd_val = scratch_q;
                default: rd_val = cycle_q;
            endcase
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        unique case (rstate_q)
            RIdle:   if (ar_hs) rstate_d = RData;
            RData:   if (R_READY) rstate_d = RIdle;
            default: rstate_d = RIdle;
        endcase
    end

    always_ff @(posedge A_CLK) begin
        if (!A_RSTn) begin
            rstate_q <= RIdle;
            r_data_q <= '0;
            r_resp_q <= RespOkay;
        end else begin
            rstate_q <= rstate_d;
            if (ar_hs) begin
                r_data_q <= rd_val;
                r_resp_q <= rd_resp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign AW_READY = aw_ready;
    assign W_READY  = w_ready;
    assign B_VALID  = (wstate_q == WResp);
    assign B_RESP   = b_resp_q;
    assign AR_READY = ar_ready;
    assign R_VALID  = (rstate_q == RData);
    assign R_DATA   = r_data_q;
    assign R_RESP   = r_resp_q;
    assign CTRL_O   = ctrl_q;
    assign CFG_O    = cfg_q;

endmodule
